// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, rippling the carry
// through a register, with a start/busy/done handshake and a held registered result.
module seq_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;

    logic [CHUNK:0]   chunk_d;
    logic [WIDTH-1:0] acc_d;

    // Per-step chunk sum including the carry rippled from the previous step
    always_comb begin
        chunk_d = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    end

    // Result bits enter the accumulator from the MSB end so the LSB chunk lands lowest
    generate
        if (STEPS == 1) begin : g_single_step
            assign acc_d = chunk_d[CHUNK-1:0];
        end else begin : g_multi_step
            assign acc_d = {chunk_d[CHUNK-1:0], acc_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    // Control FSM and datapath registers; sum/cout update only on the completion edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= {CNT_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    acc_q   <= acc_d;
                    carry_q <= chunk_d[CHUNK];
                    if (cnt_q == LAST_STEP) begin
                        sum_q   <= acc_d;
                        cout_q  <= chunk_d[CHUNK];
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed table vectors and corner sequences on the 8/2 configuration, plus a
// randomised reference-model sweep on the 8/1, 8/8 and 16/4 configurations.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, sub, cin;
    logic [7:0] a, b;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic        sw_start, sw_sub, sw_cin;
    logic [15:0] sw_a, sw_b;
    logic        busy81, done81, cout81, busy88, done88, cout88, busy164, done164, cout164;
    logic [7:0]  sum81, sum88;
    logic [15:0] sum164;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_sum;
    logic       last_cout;

    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout));

    seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut81 (
        .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a[7:0]), .b(sw_b[7:0]),
        .cin(sw_cin), .busy(busy81), .done(done81), .sum(sum81), .cout(cout81));

    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut88 (
        .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a[7:0]), .b(sw_b[7:0]),
        .cin(sw_cin), .busy(busy88), .done(done88), .sum(sum88), .cout(cout88));

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut164 (
        .clk(clk), .rst(rst), .start(sw_start), .sub(sw_sub), .a(sw_a), .b(sw_b),
        .cin(sw_cin), .busy(busy164), .done(done164), .sum(sum164), .cout(cout164));

    typedef struct packed {
        logic       sub;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8/2 operation: operands and cin are disturbed after capture; {busy,done,cout,sum} checked each cycle
    task automatic run_op(input vec_t v, input int id);
        sub = v.sub; a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("op%0d accept {busy,done,cout,sum}", id),
              {busy, done, cout, sum}, {1'b1, 1'b0, last_cout, last_sum});
        for (int i = 1; i < 4; i++) begin
            cin = ~cin; a = ~a; b = b + 8'd7; sub = ~sub;
            tick();
            check($sformatf("op%0d step%0d {busy,done,cout,sum}", id, i),
                  {busy, done, cout, sum}, {1'b1, 1'b0, last_cout, last_sum});
        end
        cin = ~cin;
        tick();
        check($sformatf("op%0d done {busy,done,cout,sum}", id),
              {busy, done, cout, sum}, {1'b0, 1'b1, v.co, v.s});
        last_sum = v.s; last_cout = v.co;
        tick();
        check($sformatf("op%0d after {busy,done}", id), {busy, done}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        mbusy, exp_done;
        int          mcnt;
        logic [7:0]  ca, cb;
        logic [8:0]  e;
        logic [15:0] ra, rb;
        logic        rs, rc;
        logic [8:0]  e8;
        logic [16:0] e16;
        int          n81, n88, n164, l81, l88, l164;

        //            sub   a      b      cin   sum    cout
        vecs[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{1'b1, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1};
        vecs[4] = '{1'b1, 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[6] = '{1'b1, 8'h80, 8'h80, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = 8'h00; b = 8'h00;
        sw_start = 1'b0; sw_sub = 1'b0; sw_cin = 1'b0; sw_a = 16'h0000; sw_b = 16'h0000;
        last_sum = 8'h00; last_cout = 1'b0;
        #22;
        check("reset {busy,done,cout,sum}", {busy, done, cout, sum}, 11'h000);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle after reset {busy,done,cout,sum}", {busy, done, cout, sum}, 11'h000);

        for (int i = 0; i < 8; i++) run_op(vecs[i], i);

        // start held high with operands changing every cycle: one op per STEPS+1 cycles
        mbusy = 1'b0; mcnt = 0; ca = 8'h00; cb = 8'h00;
        start = 1'b1; sub = 1'b0; cin = 1'b0;
        for (int c = 0; c < 15; c++) begin
            a = 8'(c * 37 + 5);
            b = 8'(c * 11 + 9);
            tick();
            exp_done = 1'b0;
            if (!mbusy) begin
                ca = a; cb = b; mbusy = 1'b1; mcnt = 0;
            end else begin
                mcnt++;
                if (mcnt == 4) begin
                    mbusy = 1'b0; exp_done = 1'b1;
                    e = {1'b0, ca} + {1'b0, cb};
                    last_sum = e[7:0]; last_cout = e[8];
                end
            end
            check($sformatf("b2b cyc%0d {busy,done,cout,sum}", c),
                  {busy, done, cout, sum}, {mbusy, exp_done, last_cout, last_sum});
        end
        start = 1'b0;
        tick();
        check("b2b tail {busy,done}", {busy, done}, 2'b00);

        // Asynchronous reset two steps into an operation
        sub = 1'b0; a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("async rst immediate {busy,done,cout,sum}", {busy, done, cout, sum}, 11'h000);
        tick();
        check("rst held {busy,done,cout,sum}", {busy, done, cout, sum}, 11'h000);
        @(negedge clk);
        rst = 1'b0;
        last_sum = 8'h00; last_cout = 1'b0;
        tick();
        check("post rst no done {busy,done,cout,sum}", {busy, done, cout, sum}, 11'h000);
        run_op('{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0}, 100);

        // Randomised sweep against the reference model on three configurations
        for (int op = 0; op < 1000; op++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            if ((op % 8) == 0) ra = 16'hFFFF;
            if ((op % 16) == 1) rb = ra;
            sw_a = ra; sw_b = rb; sw_sub = rs; sw_cin = rc; sw_start = 1'b1;
            tick();
            sw_start = 1'b0;
            sw_a = ~ra; sw_b = rb ^ 16'h5A5A; sw_sub = ~rs; sw_cin = ~rc;
            n81 = 0; n88 = 0; n164 = 0; l81 = 0; l88 = 0; l164 = 0;
            for (int cyc = 1; cyc <= 9; cyc++) begin
                tick();
                if (done81)  begin n81++;  l81  = cyc; end
                if (done88)  begin n88++;  l88  = cyc; end
                if (done164) begin n164++; l164 = cyc; end
            end
            e8  = {1'b0, ra[7:0]} + (rs ? {1'b0, ~rb[7:0]} : {1'b0, rb[7:0]}) + {8'h00, (rs ? 1'b1 : rc)};
            e16 = {1'b0, ra} + (rs ? {1'b0, ~rb} : {1'b0, rb}) + {16'h0000, (rs ? 1'b1 : rc)};
            check($sformatf("sw81 op%0d {ndone,latency}", op), {n81[15:0], l81[15:0]}, {16'd1, 16'd8});
            check($sformatf("sw88 op%0d {ndone,latency}", op), {n88[15:0], l88[15:0]}, {16'd1, 16'd1});
            check($sformatf("sw164 op%0d {ndone,latency}", op), {n164[15:0], l164[15:0]}, {16'd1, 16'd4});
            check($sformatf("sw81 op%0d {cout,sum}", op), {cout81, sum81}, e8);
            check($sformatf("sw88 op%0d {cout,sum}", op), {cout88, sum88}, e8);
            check($sformatf("sw164 op%0d {cout,sum}", op), {cout164, sum164}, e16);
        end
        check("sweep idle busy", {busy81, busy88, busy164}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
